// File: rtl/led_matrix_pkg.sv
// Shared types, state encodings and frame-indexing helpers for the LED matrix scroller.
package led_matrix_pkg;

  localparam int MTX_DIM = 8;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_FETCH = 3'd1;
  localparam state_t ST_SHIFT = 3'd2;
  localparam state_t ST_FLUSH = 3'd3;
  localparam state_t ST_FIN   = 3'd4;

  function automatic int mtx_idx(input int row, input int col);
    return row * MTX_DIM + col;
  endfunction

  // Every row moves one column left; new_col[r] enters at the rightmost column of row r.
  function automatic logic [63:0] shift_left(input logic [63:0] frm, input logic [7:0] new_col);
    logic [63:0] res;
    res = '0;
    for (int r = 0; r < MTX_DIM; r++) begin
      for (int c = 0; c < MTX_DIM - 1; c++) begin
        res[mtx_idx(r, c)] = frm[mtx_idx(r, c + 1)];
      end
      res[mtx_idx(r, MTX_DIM - 1)] = new_col[r];
    end
    return res;
  endfunction

endpackage

// File: rtl/led_matrix_step_tick.sv
// Scroll-step counter: tick_o pulses on the last cycle of each step while enabled; held while
// disabled, cleared by clr_i. Optional speed_i (LED_MATRIX_SCROLL_SPEED_EN) is latched only at a wrap.
module led_matrix_step_tick #(
  parameter int STEP_DIV = 2_500_000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  input  logic       en_i,
`ifdef LED_MATRIX_SCROLL_SPEED_EN
  input  logic [1:0] speed_i,
`endif
  output logic       tick_o
);

  localparam int CNT_W = $clog2(STEP_DIV + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] lim_q, lim_d;
  logic [CNT_W-1:0] lim_nxt;

  always_comb begin
`ifdef LED_MATRIX_SCROLL_SPEED_EN
    lim_nxt = CNT_W'(STEP_DIV >> speed_i);
    if (lim_nxt < CNT_W'(2)) lim_nxt = CNT_W'(2);
`else
    lim_nxt = CNT_W'(STEP_DIV);
`endif
  end

  assign tick_o = en_i && (cnt_q == lim_q - CNT_W'(1));

  // The divisor only changes at a step boundary so a step in progress is never shortened.
  always_comb begin
    cnt_d = cnt_q;
    lim_d = lim_q;
    if (clr_i) begin
      cnt_d = '0;
      lim_d = lim_nxt;
    end else if (en_i) begin
      if (tick_o) begin
        cnt_d = '0;
        lim_d = lim_nxt;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
      lim_q <= CNT_W'(STEP_DIV);
    end else begin
      cnt_q <= cnt_d;
      lim_q <= lim_d;
    end
  end

endmodule

// File: rtl/led_matrix_scroller.sv
// Scrolls a buffered message left across an 8x8 matrix, one glyph column per step tick.
// Writes accepted only in IDLE with space; optional speed_i input under LED_MATRIX_SCROLL_SPEED_EN.
module led_matrix_scroller
  import led_matrix_pkg::*;
#(
  parameter int MSG_DEPTH = 16,
  parameter int STEP_DIV  = 2_500_000,
  parameter int CHAR_W    = 6
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wr_valid_i,
  input  logic [7:0]  wr_code_i,
  output logic        wr_ready_o,
  input  logic        msg_clr_i,
  input  logic        start_i,
  input  logic        stop_i,
  input  logic        loop_i,
`ifdef LED_MATRIX_SCROLL_SPEED_EN
  input  logic [1:0]  speed_i,
`endif
  output logic [7:0]  char_code_o,
  input  logic [63:0] glyph_i,
  output logic [63:0] frame_o,
  output logic        busy_o,
  output logic        done_o
);

  localparam int AW = (MSG_DEPTH > 1) ? $clog2(MSG_DEPTH) : 1;
  localparam int CW = $clog2(MSG_DEPTH) + 1;

  state_t          state_q, state_d;
  logic [7:0]      buf_q [MSG_DEPTH];
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [2:0]      col_idx_q, col_idx_d;
  logic [2:0]      flush_cnt_q, flush_cnt_d;
  logic [63:0]     frame_q, frame_d;
  logic [7:0]      char_code_q, char_code_d;
  logic            done_q, done_d;
  logic            tick, wr_fire, last_char, last_col;
  logic [MTX_DIM-1:0] glyph_col;

  led_matrix_step_tick #(.STEP_DIV(STEP_DIV)) u_step_tick (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (state_q == ST_IDLE),
    .en_i    ((state_q == ST_SHIFT) || (state_q == ST_FLUSH)),
`ifdef LED_MATRIX_SCROLL_SPEED_EN
    .speed_i (speed_i),
`endif
    .tick_o  (tick)
  );

  assign wr_ready_o  = (state_q == ST_IDLE) && (count_q < CW'(MSG_DEPTH));
  assign wr_fire     = wr_valid_i && wr_ready_o && !msg_clr_i;
  assign last_char   = (CW'(rd_ptr_q) + CW'(1)) == count_q;
  assign last_col    = col_idx_q == 3'(CHAR_W - 1);
  assign char_code_o = char_code_q;
  assign frame_o     = frame_q;
  assign busy_o      = state_q != ST_IDLE;
  assign done_o      = done_q;

  always_comb begin
    glyph_col = '0;
    for (int r = 0; r < MTX_DIM; r++) begin
      glyph_col[r] = glyph_i[mtx_idx(r, int'(col_idx_q))];
    end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    col_idx_d   = col_idx_q;
    flush_cnt_d = flush_cnt_q;
    frame_d     = frame_q;
    char_code_d = char_code_q;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (msg_clr_i) begin
          count_d = '0;
        end else begin
          if (wr_fire) count_d = count_q + CW'(1);
          if (start_i && (count_q != '0)) begin
            state_d   = ST_FETCH;
            rd_ptr_d  = '0;
            col_idx_d = '0;
          end
        end
      end
      ST_FETCH: begin
        char_code_d = buf_q[rd_ptr_q];
        state_d     = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (tick) begin
          frame_d = shift_left(frame_q, glyph_col);
          if (last_col) begin
            col_idx_d   = '0;
            rd_ptr_d    = rd_ptr_q + AW'(1);
            flush_cnt_d = '0;
            state_d     = last_char ? ST_FLUSH : ST_FETCH;
          end else begin
            col_idx_d = col_idx_q + 3'd1;
          end
        end
      end
      ST_FLUSH: begin
        if (tick) begin
          frame_d     = shift_left(frame_q, 8'h00);
          flush_cnt_d = flush_cnt_q + 3'd1;
          if (flush_cnt_q == 3'd7) begin
            if (loop_i) begin
              state_d  = ST_FETCH;
              rd_ptr_d = '0;
            end else begin
              state_d = ST_FIN;
            end
          end
        end
      end
      ST_FIN: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Abort wins over any tick landing in the same cycle.
    if (stop_i && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      frame_d = '0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_fire) buf_q[count_q[AW-1:0]] <= wr_code_i;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      col_idx_q   <= '0;
      flush_cnt_q <= '0;
      frame_q     <= '0;
      char_code_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      col_idx_q   <= col_idx_d;
      flush_cnt_q <= flush_cnt_d;
      frame_q     <= frame_d;
      char_code_q <= char_code_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: doc/led_matrix_scroller.md
Name: led_matrix_scroller

Overview:
Sequencer that scrolls a stored message of character codes leftward across an 8x8 LED matrix. It holds up to MSG_DEPTH codes and presents one code at a time to the external 8x8 glyph decoder. It takes the returned 64-bit glyph and shifts one glyph column per scroll step into a 64-bit frame that feeds the 8x8 matrix driver. Frame bit index is row*8+col: col 0 is leftmost, row 0 is top, and 1 means illuminated.

Parameters:
MSG_DEPTH, 16, message buffer depth in codes (power of 2, 2..256)
STEP_DIV, 2_500_000, clk cycles per scroll step (>=2)
CHAR_W, 6, glyph columns taken per character, glyph cols 0..CHAR_W-1 (1..8)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
wr_valid  in  1  message write request
wr_code  in  8  character code to append
wr_ready  out  1  write accepted when wr_valid&&wr_ready at posedge
msg_clr  in  1  empty message buffer (IDLE only; ignored otherwise)
start  in  1  begin scrolling (IDLE only)
stop  in  1  abort scrolling
loop  in  1  sampled at end of message: 1 = restart, 0 = finish
char_code  out  8  code presented to glyph decoder
glyph  in  64  decoder output for char_code (combinational, same cycle)
frame  out  64  display array to matrix driver
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse on normal completion

Behaviour:
- Reset (rst low, async): state IDLE, frame=0, char_code=0, count=0, rd_ptr=0, done=0, busy=0, step counter=0.
- Buffer: linear array, count 0..MSG_DEPTH. wr_ready = (state==IDLE) && (count<MSG_DEPTH). An accepted write stores at index count, then count increments. A full buffer drops writes because wr_ready is low.
- msg_clr in IDLE sets count=0 and takes priority over a same-cycle write. start in the same cycle as msg_clr is ignored.
- start in IDLE with count==0 is ignored and no done pulse is issued.
- FSM states: IDLE, FETCH, SHIFT, FLUSH, FIN.
- IDLE -> FETCH on start && count>0. rd_ptr=0, col_idx=0, step counter cleared.
- FETCH (1 cycle): char_code <= buf[rd_ptr]. Glyph is valid the next cycle. -> SHIFT.
- Scroll step: step tick fires when the step counter reaches STEP_DIV-1; the counter then wraps to 0. The counter runs only in SHIFT and FLUSH.
- SHIFT: on a tick, every row shifts left: frame[r*8+c] <= frame[r*8+c+1] for c=0..6, and frame[r*8+7] <= glyph[r*8+col_idx]. Then col_idx increments.
  - When col_idx reaches CHAR_W-1 on a tick, col_idx resets to 0 and rd_ptr increments.
  - If rd_ptr was count-1, go to FLUSH with flush_cnt=0. Otherwise go to FETCH.
- FLUSH: on each tick, shift left and insert 0 in col 7. After 8 ticks the frame is blank.
  - If loop=1: go to FETCH with rd_ptr=0.
  - If loop=0: go to FIN.
- FIN (1 cycle): done=1 -> IDLE.
- Latency: the first new column appears STEP_DIV+1 cycles after start is accepted. One character takes CHAR_W*STEP_DIV cycles plus 1 FETCH cycle.
- stop (any non-IDLE state) -> IDLE next cycle. Effects: frame=0, no done pulse, buffer contents and count retained. stop has priority over a same-cycle tick.
- The frame only changes on ticks, on stop (clears to 0) and on reset (clears to 0).

Optional Feature:
- LED_MATRIX_SCROLL_SPEED_EN defined: adds input speed[1:0]. The effective divisor is STEP_DIV>>speed, floor 2. speed is sampled only when the step counter wraps, so a change never shortens the step in progress.
- Macro undefined: the port is absent and the divisor is fixed at STEP_DIV.

Decomposition:
- Package led_matrix_pkg:
  - state enum (IDLE, FETCH, SHIFT, FLUSH, FIN)
  - constant MTX_DIM=8
  - function/constant for row*8+col indexing
- One sub-module, led_matrix_step_tick: step counter and tick generator, with enable and the optional speed shift.

Test Plan:
- STEP_DIV=4, CHAR_W=6: write codes 1,2,3 -> wr_ready stays 1, count=3. Write 17 codes into MSG_DEPTH=16 -> 17th not accepted, wr_ready=0 after the 16th.
- Buffer {code whose glyph = 64'h00000000000000FF}, CHAR_W=8, loop=0, start -> row 0 fills one column per 4 cycles. After 8 ticks frame=64'hFF; after 8 more flush ticks frame=0. done pulses once, busy falls the same cycle.
- Two codes, loop=1 -> after the flush, char_code returns to the first code and busy stays 1. Drop loop -> done pulses after the next flush.
- stop 3 cycles after the first tick -> IDLE next cycle, frame=0, no done. Immediate start rescrolls from code 0 with count unchanged.
- start with count=0 -> busy stays 0. msg_clr and wr_valid in the same cycle -> count=0.
- Assert rst low mid-SHIFT, asynchronously between clock edges -> frame=0, busy=0 and count=0 immediately. Outputs stay at their reset values until rst rises.
